pool2d_stream: RTL and testbench

//  Parametrised streaming 2-D pooling layer; successor to the fixed 6x6 / 2x2 average-pool layer.

---
 rtl/pool2d_stream_if.sv | 7 +
 rtl/pool2d_stream.sv | 94 +++++++++
 tb/tb_pool2d_stream.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool2d_stream_if.sv
// pool2d_stream_if: pixel-in / pooled-pixel-out valid/ready stream pair.
interface pool2d_stream_if #(parameter int DATA_W = 32);
    logic                     in_valid, in_ready, out_valid, out_ready, out_last;
    logic signed [DATA_W-1:0] in_data, out_data;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_last);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming non-overlapping POOLxPOOL average/max pooling over a raster feature map.
module pool2d_stream #(
    parameter int DATA_W = 32,
    parameter int FM_W   = 6,
    parameter int FM_H   = 6,
    parameter int POOL   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mode,
    pool2d_stream_if.slave  s,
    output logic            frame_done,
    output logic            busy
);
    localparam int LP    = $clog2(POOL);
    localparam int ACC_W = DATA_W + 2*LP;
    localparam int NA    = FM_W / POOL;
    localparam int CW    = $clog2(FM_W);
    localparam int RW    = $clog2(FM_H);
    localparam int IW    = NA > 1 ? $clog2(NA) : 1;
    localparam logic [CW-1:0] CMAX = CW'(FM_W - 1);
    localparam logic [RW-1:0] RMAX = RW'(FM_H - 1);

    if (POOL < 2 || (POOL & (POOL - 1)) != 0 || FM_W % POOL != 0 || FM_H % POOL != 0) begin : g_bad_params
        $error("pool2d_stream: POOL must be a power of two >= 2 dividing FM_W and FM_H");
    end

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_n;

    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic [IW-1:0]           idx;
    logic signed [ACC_W-1:0] acc [NA];
    logic signed [ACC_W-1:0] sx, cur, comb_v;
    logic mode_q, mode_e, in_fire, out_fire, first, final_px, last_px;

    assign in_fire  = s.in_valid & s.in_ready;
    assign out_fire = s.out_valid & s.out_ready;

    always_ff @(posedge clk)
        state <= !rst ? IDLE : state_n;

    always_comb
        state_n = state == IDLE ? (in_fire ? RUN : IDLE)
                : state == RUN  ? (in_fire && last_px ? FLUSH : RUN)
                :                 (out_fire && s.out_last ? IDLE : FLUSH);

    always_comb begin
        s.in_ready = state != FLUSH && !(s.out_valid && !s.out_ready);
        busy       = state != IDLE;
    end

    // The pixel that starts a frame must already see the live mode input.
    always_comb begin
        mode_e   = state == IDLE ? mode : mode_q;
        idx      = IW'(col >> LP);
        sx       = ACC_W'(s.in_data);
        cur      = acc[idx];
        comb_v   = mode_e ? (sx > cur ? sx : cur) : cur + sx;
        first    = row[LP-1:0] == '0 && col[LP-1:0] == '0;
        final_px = &row[LP-1:0] && &col[LP-1:0];
        last_px  = col == CMAX && row == RMAX;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col         <= '0;
            row         <= '0;
            mode_q      <= 1'b0;
            frame_done  <= 1'b0;
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
            s.out_last  <= 1'b0;
            for (int i = 0; i < NA; i++) acc[i] <= '0;
        end else begin
            frame_done <= out_fire && s.out_last;
            if (state == IDLE && in_fire) mode_q <= mode;
            if (in_fire) begin
                acc[idx] <= first ? sx : comb_v;
                col      <= col == CMAX ? '0 : col + 1'b1;
                if (col == CMAX) row <= row == RMAX ? '0 : row + 1'b1;
            end
            if (in_fire && final_px) begin
                s.out_valid <= 1'b1;
                s.out_data  <= mode_e ? DATA_W'(comb_v) : DATA_W'(comb_v >>> (2*LP));
                s.out_last  <= last_px;
            end else if (out_fire) begin
                s.out_valid <= 1'b0;
                s.out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pool2d_stream.sv
// tb_pool2d_stream: randomized and directed checks of pool2d_stream against a window-arithmetic model.
module tb_pool2d_stream;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mode_a = 1'b0, mode_b = 1'b0;
    logic fd_a, fd_b, busy_a, busy_b;
    always #5 clk = ~clk;

    pool2d_stream_if #(.DATA_W(32)) a ();
    pool2d_stream_if #(.DATA_W(32)) b ();

    pool2d_stream #(.DATA_W(32), .FM_W(6), .FM_H(6), .POOL(2)) dut_a (
        .clk(clk), .rst(rst), .mode(mode_a), .s(a), .frame_done(fd_a), .busy(busy_a));
    pool2d_stream #(.DATA_W(32), .FM_W(8), .FM_H(4), .POOL(4)) dut_b (
        .clk(clk), .rst(rst), .mode(mode_b), .s(b), .frame_done(fd_b), .busy(busy_b));

    int     n_chk = 0, n_fail = 0;
    longint cyc = 0;
    bit     sel = 1'b0;
    int     px_q[$], exp_q[$], got_d[$];
    bit     got_l[$];
    longint got_c[$], done_c[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!sel && a.out_valid && a.out_ready) begin
            got_d.push_back(a.out_data); got_l.push_back(a.out_last); got_c.push_back(cyc);
        end
        if (sel && b.out_valid && b.out_ready) begin
            got_d.push_back(b.out_data); got_l.push_back(b.out_last); got_c.push_back(cyc);
        end
        if (sel ? fd_b : fd_a) done_c.push_back(cyc);
    end

    task automatic clr();
        got_d.delete(); got_l.delete(); got_c.delete(); done_c.delete();
    endtask

    task automatic ramp(input int n);
        px_q.delete();
        for (int i = 0; i < n; i++) px_q.push_back(i);
    endtask

    task automatic rnd(input int n);
        px_q.delete();
        for (int i = 0; i < n; i++) px_q.push_back(int'($urandom));
    endtask

    // Expected pooled outputs straight from the window definition, appended to exp_q.
    task automatic model(input int w, input int h, input int p, input bit m);
        int sh = 2 * $clog2(p);
        for (int wr = 0; wr < h / p; wr++)
            for (int wc = 0; wc < w / p; wc++) begin
                longint sum = 0;
                int mx = px_q[wr * p * w + wc * p];
                for (int r = 0; r < p; r++)
                    for (int c = 0; c < p; c++) begin
                        int v = px_q[(wr * p + r) * w + wc * p + c];
                        sum += v;
                        if (v > mx) mx = v;
                    end
                exp_q.push_back(m ? mx : int'(sum >>> sh));
            end
    endtask

    task automatic drive_px(input int d);
        int k = 0;
        bit ok = 1'b0;
        if (sel) begin b.in_valid = 1'b1; b.in_data = d; end
        else     begin a.in_valid = 1'b1; a.in_data = d; end
        while (!ok && k < 200) begin
            @(negedge clk);
            ok = sel ? b.in_ready : a.in_ready;
            @(posedge clk); #1;
            k++;
        end
        a.in_valid = 1'b0; b.in_valid = 1'b0;
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL drive_timeout pixel %0d not accepted within %0d cycles", d, k); end
    endtask

    task automatic send_frame(input bit m, input bit toggle);
        for (int i = 0; i < px_q.size(); i++) begin
            if (i == 0) begin if (sel) mode_b = m; else mode_a = m; end
            if (toggle && i == px_q.size() / 2) begin if (sel) mode_b = ~m; else mode_a = ~m; end
            drive_px(px_q[i]);
        end
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        while (done_c.size() < n && k < 400) begin @(posedge clk); #1; k++; end
        @(posedge clk); #1;
        n_chk++;
        if (done_c.size() != n) begin n_fail++; $display("FAIL frame_done_count got %0d want %0d", done_c.size(), n); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk++; if (a.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", a.out_valid); end
        n_chk++; if (a.out_data !== 32'd0) begin n_fail++; $display("FAIL rst_out_data got %0h want 0", a.out_data); end
        n_chk++; if (a.out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last got %b want 0", a.out_last); end
        n_chk++; if (a.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", a.in_ready); end
        n_chk++; if (fd_a !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done got %b want 0", fd_a); end
        n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy_a); end
        n_chk++; if (b.in_ready !== 1'b1 || b.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b got rdy=%b vld=%b want 1/0", b.in_ready, b.out_valid); end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_avg_ramp();
        int t[9] = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
        sel = 1'b0; a.out_ready = 1'b1; ramp(36); clr();
        send_frame(1'b0, 1'b0);
        wait_done(1);
        n_chk++; if (got_d.size() != 9) begin n_fail++; $display("FAIL t1_count got %0d want 9", got_d.size()); end
        for (int i = 0; i < 9 && i < got_d.size(); i++) begin
            n_chk++; if (got_d[i] !== t[i] || got_l[i] !== (i == 8)) begin n_fail++;
                $display("FAIL t1_out[%0d] got %0d last=%b want %0d last=%b", i, got_d[i], got_l[i], t[i], i == 8); end
        end
        n_chk++; if (got_c.size() == 0 || done_c.size() == 0 || done_c[0] !== got_c[got_c.size()-1] + 1) begin n_fail++;
            $display("FAIL t1_done_timing got done=%0d want last_fire+1", done_c.size() ? done_c[0] : -1); end
        n_chk++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL t1_busy_after got %b want 0", busy_a); end
    endtask

    task automatic test_max_ramp();
        int t[9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
        sel = 1'b0; a.out_ready = 1'b1; ramp(36); clr();
        send_frame(1'b1, 1'b0);
        wait_done(1);
        n_chk++; if (got_d.size() != 9) begin n_fail++; $display("FAIL t2_count got %0d want 9", got_d.size()); end
        for (int i = 0; i < 9 && i < got_d.size(); i++) begin
            n_chk++; if (got_d[i] !== t[i] || got_l[i] !== (i == 8)) begin n_fail++;
                $display("FAIL t2_out[%0d] got %0d last=%b want %0d last=%b", i, got_d[i], got_l[i], t[i], i == 8); end
        end
    endtask

    task automatic test_neg_round();
        sel = 1'b0; a.out_ready = 1'b1; rnd(36); clr();
        px_q[0] = -1; px_q[1] = -1; px_q[6] = -1; px_q[7] = -2;
        exp_q.delete(); model(6, 6, 2, 1'b0);
        send_frame(1'b0, 1'b0);
        wait_done(1);
        n_chk++; if (got_d.size() == 0 || got_d[0] !== 32'hFFFFFFFE) begin n_fail++;
            $display("FAIL t3_neg_round got %0h want fffffffe", got_d.size() ? got_d[0] : 0); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_chk++; if (i >= got_d.size() || got_d[i] !== exp_q[i]) begin n_fail++;
                $display("FAIL t3_out[%0d] got %0d want %0d", i, i < got_d.size() ? got_d[i] : 0, exp_q[i]); end
        end
    endtask

    task automatic test_random();
        sel = 1'b0; a.out_ready = 1'b1;
        for (int f = 0; f < 4; f++) begin
            bit m = f[0];
            rnd(36); clr(); exp_q.delete(); model(6, 6, 2, m);
            send_frame(m, 1'b0);
            wait_done(1);
            n_chk++; if (got_d.size() != exp_q.size()) begin n_fail++; $display("FAIL rand%0d_count got %0d want %0d", f, got_d.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
                n_chk++; if (got_d[i] !== exp_q[i] || got_l[i] !== (i == exp_q.size() - 1)) begin n_fail++;
                    $display("FAIL rand%0d_out[%0d] got %0d last=%b want %0d", f, i, got_d[i], got_l[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int t[9] = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
        sel = 1'b0; a.out_ready = 1'b0; ramp(36); clr();
        fork
            send_frame(1'b0, 1'b0);
            begin
                int k = 0;
                @(negedge clk);
                while (!a.out_valid && k < 100) begin @(negedge clk); k++; end
                repeat (5) begin
                    n_chk++; if (a.out_data !== 32'd3 || a.in_ready !== 1'b0 || busy_a !== 1'b1) begin n_fail++;
                        $display("FAIL t4_stall got data=%0d rdy=%b busy=%b want 3/0/1", a.out_data, a.in_ready, busy_a); end
                    @(negedge clk);
                end
                @(posedge clk); #1;
                a.out_ready = 1'b1;
            end
        join
        wait_done(1);
        n_chk++; if (got_d.size() != 9) begin n_fail++; $display("FAIL t4_count got %0d want 9", got_d.size()); end
        for (int i = 0; i < 9 && i < got_d.size(); i++) begin
            n_chk++; if (got_d[i] !== t[i]) begin n_fail++; $display("FAIL t4_out[%0d] got %0d want %0d", i, got_d[i], t[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int t[9] = '{3, 5, 7, 15, 17, 19, 27, 29, 31};
        sel = 1'b0; a.out_ready = 1'b1; ramp(36);
        mode_a = 1'b1;
        for (int i = 0; i < 20; i++) drive_px(px_q[i] + 100);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        n_chk++; if (a.out_valid !== 1'b0 || a.out_data !== 32'd0 || a.out_last !== 1'b0 || busy_a !== 1'b0 || a.in_ready !== 1'b1) begin n_fail++;
            $display("FAIL t5_reset got vld=%b data=%0d last=%b busy=%b rdy=%b want 0/0/0/0/1", a.out_valid, a.out_data, a.out_last, busy_a, a.in_ready); end
        @(posedge clk); #1;
        rst = 1'b1; clr();
        send_frame(1'b0, 1'b0);
        wait_done(1);
        n_chk++; if (got_d.size() != 9) begin n_fail++; $display("FAIL t5_count got %0d want 9", got_d.size()); end
        for (int i = 0; i < 9 && i < got_d.size(); i++) begin
            n_chk++; if (got_d[i] !== t[i]) begin n_fail++; $display("FAIL t5_out[%0d] got %0d want %0d", i, got_d[i], t[i]); end
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0; a.out_ready = 1'b1; clr(); exp_q.delete();
        rnd(36); model(6, 6, 2, 1'b0); send_frame(1'b0, 1'b0);
        rnd(36); model(6, 6, 2, 1'b1); send_frame(1'b1, 1'b0);
        wait_done(2);
        n_chk++; if (got_d.size() != 18) begin n_fail++; $display("FAIL b2b_count got %0d want 18", got_d.size()); end
        for (int i = 0; i < 18 && i < got_d.size(); i++) begin
            n_chk++; if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 8 || i == 17)) begin n_fail++;
                $display("FAIL b2b_out[%0d] got %0d last=%b want %0d", i, got_d[i], got_l[i], exp_q[i]); end
        end
    endtask

    task automatic test_params();
        int ta[2] = '{13, 17};
        int tm[2] = '{27, 31};
        sel = 1'b1; b.out_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            ramp(32); clr();
            send_frame(pass[0], 1'b1);
            wait_done(1);
            n_chk++; if (got_d.size() != 2) begin n_fail++; $display("FAIL t6_count[%0d] got %0d want 2", pass, got_d.size()); end
            for (int i = 0; i < 2 && i < got_d.size(); i++) begin
                n_chk++; if (got_d[i] !== (pass ? tm[i] : ta[i]) || got_l[i] !== (i == 1)) begin n_fail++;
                    $display("FAIL t6_out[%0d][%0d] got %0d last=%b want %0d", pass, i, got_d[i], got_l[i], pass ? tm[i] : ta[i]); end
            end
            n_chk++; if (got_c.size() == 0 || done_c.size() == 0 || done_c[0] !== got_c[got_c.size()-1] + 1) begin n_fail++;
                $display("FAIL t6_done_timing[%0d] got %0d entries", pass, done_c.size()); end
        end
        rnd(32); clr(); exp_q.delete(); model(8, 4, 4, 1'b0);
        send_frame(1'b0, 1'b1);
        wait_done(1);
        for (int i = 0; i < 2; i++) begin
            n_chk++; if (i >= got_d.size() || got_d[i] !== exp_q[i]) begin n_fail++;
                $display("FAIL t6_rand[%0d] got %0d want %0d", i, i < got_d.size() ? got_d[i] : 0, exp_q[i]); end
        end
        sel = 1'b0;
    endtask

    initial begin
        a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b1;
        b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b1;
        test_reset();
        test_avg_ramp();
        test_max_ramp();
        test_neg_round();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
